load_store_unit: RTL and testbench

Data-memory access engine for the memory/writeback stage of the 3-stage RV32I core.
- Accepts one load or store per request from the memory/writeback stage.
- Drives a single-outstanding req/ack data bus.
- Aligns store data into byte strobes, and extracts/extends load data for register writeback.
- Reports completion to the controller so the pipeline can stall on slow memory.

---
 rtl/load_store_unit.sv | 201 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store engine with a single-outstanding req/ack data bus.
// Optional bus timeout is compiled in by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_num,
    output logic        busy,
    output logic        done,
    output logic        wb_enable,
    output logic [4:0]  wb_rd_num,
    output logic [31:0] wb_rd_data,
    output logic        misaligned,
    output logic        illegal_op,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_func3;
    logic [4:0]  r_rd_num;
    logic        r_is_load;
    logic        r_is_store;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic [4:0]  r_wb_rd_num;
    logic [31:0] r_wb_rd_data;
    logic        r_misaligned;
    logic        r_illegal;
    logic        r_bus_error;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_fault;
    logic        w_timeout;
    logic [3:0]  w_strb;
    logic [31:0] w_lanes;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    // 010 only reaches the misalignment test as a word; 110 is already illegal
    assign w_illegal    = (r_is_load == r_is_store) || (r_func3 == 3'b011) ||
                          (r_func3[2:1] == 2'b11) || (r_is_store && r_func3[2]);
    assign w_misaligned = ((r_func3[1:0] == 2'b01) && r_addr[0]) ||
                          ((r_func3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_fault      = w_illegal || w_misaligned;

    always_comb begin
        w_strb  = 4'b1111;
        w_lanes = r_wdata;
        case (r_func3[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << r_addr[1:0];
                w_lanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << r_addr[1:0];
                w_lanes = {2{r_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (r_func3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_cnt;

    // Held at zero outside REQ, so it starts from zero on every REQ entry
    always_ff @(posedge clk) begin
        if (rst || r_state != S_REQ) r_cnt <= '0;
        else if (!mem_ack)           r_cnt <= r_cnt + CW'(1);
    end
    assign w_timeout = (r_state == S_REQ) && !mem_ack && (r_cnt == LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CHECK;
            S_CHECK: w_next = w_fault ? S_RESP : S_REQ;
            S_REQ:   if (mem_ack || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_RESP);
        wb_enable = (r_state == S_RESP) && r_is_load && !r_illegal && !r_misaligned &&
                    !r_bus_error && (r_wb_rd_num != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_func3      <= '0;
            r_rd_num     <= '0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wstrb  <= '0;
            r_mem_wdata  <= '0;
            r_wb_rd_num  <= '0;
            r_wb_rd_data <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_addr     <= addr;
                    r_wdata    <= wdata;
                    r_func3    <= func3;
                    r_rd_num   <= rd_num;
                    r_is_load  <= is_load;
                    r_is_store <= is_store;
                end
                S_CHECK: if (w_fault) begin
                    r_illegal    <= w_illegal;
                    r_misaligned <= !w_illegal;
                    r_bus_error  <= 1'b0;
                    r_wb_rd_num  <= r_rd_num;
                end else begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= r_is_store;
                    r_mem_addr  <= {r_addr[31:2], 2'b00};
                    r_mem_wstrb <= r_is_store ? w_strb : 4'b0000;
                    r_mem_wdata <= w_lanes;
                end
                S_REQ: if (mem_ack || w_timeout) begin
                    r_mem_req    <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_mem_wstrb  <= 4'b0000;
                    r_illegal    <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_bus_error  <= !mem_ack;
                    r_wb_rd_num  <= r_rd_num;
                    if (mem_ack && r_is_load) r_wb_rd_data <= w_load_data;
                end
                default: ;
            endcase
        end
    end

    assign wb_rd_num  = r_wb_rd_num;
    assign wb_rd_data = r_wb_rd_data;
    assign misaligned = r_misaligned;
    assign illegal_op = r_illegal;
    assign bus_error  = r_bus_error;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wstrb  = r_mem_wstrb;
    assign mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - Self-checking bench for load_store_unit with a behavioural access model.
// Timeout cases run only when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst, start, is_load, is_store, mem_ack;
    logic [2:0]  func3;
    logic [31:0] addr, wdata, mem_rdata;
    logic [4:0]  rd_num;
    logic        busy, done, wb_enable, misaligned, illegal_op, bus_error, mem_req, mem_we;
    logic [4:0]  wb_rd_num;
    logic [31:0] wb_rd_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .func3(func3), .addr(addr), .wdata(wdata), .rd_num(rd_num),
        .busy(busy), .done(done), .wb_enable(wb_enable), .wb_rd_num(wb_rd_num),
        .wb_rd_data(wb_rd_data), .misaligned(misaligned), .illegal_op(illegal_op),
        .bus_error(bus_error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        bit          ill;
        bit          mis;
        bit          berr;
        bit          we;
        logic [3:0]  strb;
        logic [31:0] addrw;
        logic [31:0] lanes;
        logic [31:0] ld;
    } exp_t;

    exp_t        cur;
    logic [4:0]  cur_rd;
    bit          cur_load;
    bit          in_op;
    logic [31:0] last_ld;
    logic [31:0] exp_ld;
    logic [3:0]  seen_strb;
    logic [31:0] seen_wdata;
    int          seen_rc;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected behaviour from access size, byte offset and plain arithmetic
    function automatic exp_t model(input bit l, input bit s, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          bytes;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        bytes   = 1 << (f3 % 4);
        off     = a % 4;
        e.ill   = (l == s) || (f3 == 3) || (f3 >= 6) || (s && f3 >= 4);
        e.mis   = !e.ill && ((a % bytes) != 0);
        e.berr  = 1'b0;
        e.we    = s;
        e.addrw = a - off;
        e.strb  = s ? 4'(((1 << bytes) - 1) << off) : 4'b0000;
        if (bytes == 1)      e.lanes = wd[7:0] * 32'h01010101;
        else if (bytes == 2) e.lanes = wd[15:0] * 32'h00010001;
        else                 e.lanes = wd;
        mask = (bytes >= 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * bytes)) - 1);
        v    = (rdata >> (8 * off)) & mask;
        if (f3 < 4 && bytes < 4 && v > (mask >> 1)) v = v | ~mask;
        e.ld = v;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            last_ld = 32'h0;
        end else begin
            check("busy", busy, in_op);
            if (!in_op) check("done_idle", done, 0);
            if (!done) check("wb_enable_idle", wb_enable, 0);
            if (done) begin
                exp_ld = (cur_load && !cur.ill && !cur.mis && !cur.berr) ? cur.ld : last_ld;
                check("wb_enable", wb_enable, (cur_load && !cur.ill && !cur.mis && !cur.berr && cur_rd != 0));
                check("wb_rd_data", wb_rd_data, exp_ld);
                last_ld = exp_ld;
                check("wb_rd_num", wb_rd_num, cur_rd);
                check("illegal_op", illegal_op, cur.ill);
                check("misaligned", misaligned, cur.mis);
                check("bus_error", bus_error, cur.berr);
            end
            if (mem_req) begin
                check("mem_we", mem_we, cur.we);
                check("mem_addr", mem_addr, cur.addrw);
                check("mem_wstrb", mem_wstrb, cur.strb);
                check("mem_wdata", mem_wdata, cur.lanes);
            end else begin
                check("mem_we_idle", mem_we, 0);
                check("mem_wstrb_idle", mem_wstrb, 0);
            end
            if (in_op && (cur.ill || cur.mis)) check("no_bus_on_fault", mem_req, 0);
        end
    end

    task automatic run_op(input bit l, input bit s, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                          input int waits, input bit to, input bit extra, input bit noise,
                          input int exp_d);
        bit seen;
        cur = model(l, s, f3, a, wd, rdata);
        if (to) cur.berr = 1'b1;
        cur_rd = rd;
        cur_load = l && !s;
        start = 1'b1; is_load = l; is_store = s; func3 = f3; addr = a; wdata = wd; rd_num = rd;
        @(posedge clk); #1;
        in_op = 1'b1;
        if (extra) begin
            addr = ~a; wdata = ~wd; rd_num = ~rd; func3 = 3'b010;
        end else begin
            start = 1'b0;
        end
        seen = 1'b0;
        seen_rc = 0;
        for (int e = 0; e < 40 && !seen; e++) begin
            if (done) begin
                seen = 1'b1;
                check("latency", e + 1, exp_d);
                start = 1'b0;
                mem_ack = 1'b0;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = ~rdata;
                if (mem_req) begin
                    seen_rc++;
                    if (seen_rc == 1) begin
                        seen_strb = mem_wstrb;
                        seen_wdata = mem_wdata;
                    end
                    if (!to && seen_rc == waits + 1) begin
                        mem_ack = 1'b1;
                        mem_rdata = rdata;
                    end
                end else begin
                    mem_ack = noise;
                end
                @(posedge clk); #1;
            end
        end
        check("done_seen", seen, 1);
        start = 1'b0;
        @(posedge clk); #1;
        in_op = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; func3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; rd_num = 5'd0; mem_rdata = 32'h0; mem_ack = 1'b0;
        in_op = 1'b0; cur = model(1, 0, 3'b010, 32'h0, 32'h0, 32'h0); cur_rd = 5'd0; cur_load = 1'b0;
        last_ld = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wb_enable", wb_enable, 0);
        check("rst_wb_rd_num", wb_rd_num, 0);
        check("rst_wb_rd_data", wb_rd_data, 0);
        check("rst_flags", {misaligned, illegal_op, bus_error}, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // LW aligned, no wait states
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 3);
        check("lw_data_lit", wb_rd_data, 32'hDEADBEEF);
        check("lw_rd_lit", wb_rd_num, 5);
        check("lw_strb_lit", seen_strb, 4'b0000);
        // LB / LBU top byte
        run_op(1, 0, 3'b000, 32'h103, 32'h0, 5'd6, 32'h80FF1234, 0, 0, 0, 0, 3);
        check("lb_lit", wb_rd_data, 32'hFFFFFF80);
        run_op(1, 0, 3'b100, 32'h103, 32'h0, 5'd6, 32'h80FF1234, 0, 0, 0, 0, 3);
        check("lbu_lit", wb_rd_data, 32'h00000080);
        // SH upper half with 3 wait states
        run_op(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 5'd9, 32'h0, 3, 0, 0, 0, 6);
        check("sh_strb_lit", seen_strb, 4'b1100);
        check("sh_wdata_lit", seen_wdata, 32'hABCDABCD);
        check("sh_req_cycles", seen_rc, 4);
        check("sh_wb_hold_lit", wb_rd_data, 32'h00000080);
        // Faults, with stray acks outside REQ
        run_op(1, 0, 3'b010, 32'h101, 32'h0, 5'd3, 32'h0, 0, 0, 0, 1, 2);
        check("lw_mis_lit", misaligned, 1);
        run_op(1, 0, 3'b011, 32'h100, 32'h0, 5'd3, 32'h0, 0, 0, 0, 1, 2);
        check("ill_f3_lit", illegal_op, 1);
        run_op(1, 1, 3'b010, 32'h100, 32'h0, 5'd3, 32'h0, 0, 0, 0, 0, 2);
        run_op(0, 1, 3'b100, 32'h100, 32'h0, 5'd3, 32'h0, 0, 0, 0, 0, 2);
        run_op(0, 0, 3'b000, 32'h100, 32'h0, 5'd3, 32'h0, 0, 0, 0, 0, 2);
        // Load to x0 while start is held throughout
        run_op(1, 0, 3'b001, 32'h102, 32'h0, 5'd0, 32'h80010000, 0, 0, 1, 0, 3);
        check("lh_lit", wb_rd_data, 32'hFFFF8001);
        run_op(1, 0, 3'b101, 32'h102, 32'h0, 5'd31, 32'h80015555, 1, 0, 0, 1, 4);
        check("lhu_lit", wb_rd_data, 32'h00008001);
        run_op(0, 1, 3'b000, 32'h101, 32'h12345677, 5'd1, 32'h0, 0, 0, 0, 0, 3);
        check("sb_strb_lit", seen_strb, 4'b0010);
        check("sb_wdata_lit", seen_wdata, 32'h77777777);
        run_op(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 5'd1, 32'h0, 0, 0, 0, 0, 3);
        run_op(1, 0, 3'b000, 32'h10E, 32'h0, 5'd12, 32'h00420000, 2, 0, 0, 0, 5);
        check("lb_pos_lit", wb_rd_data, 32'h00000042);

        // Reset while a load waits in REQ
        cur = model(1, 0, 3'b010, 32'h200, 32'h0, 32'h0);
        cur_rd = 5'd7; cur_load = 1'b1;
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; func3 = 3'b010; addr = 32'h200; rd_num = 5'd7;
        @(posedge clk); #1;
        in_op = 1'b1; start = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("req_before_rst", mem_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        in_op = 1'b0;
        check("req_after_rst", mem_req, 0);
        check("busy_after_rst", busy, 0);
        check("wb_data_after_rst", wb_rd_data, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        run_op(1, 0, 3'b010, 32'h300, 32'h0, 5'd8, 32'h01234567, 0, 0, 0, 0, 3);
        check("post_rst_lw_lit", wb_rd_data, 32'h01234567);

`ifdef LSU_TIMEOUT_EN
        run_op(1, 0, 3'b010, 32'h400, 32'h0, 5'd4, 32'h11111111, 0, 1, 0, 0, 6);
        check("timeout_lit", bus_error, 1);
        run_op(1, 0, 3'b010, 32'h400, 32'h0, 5'd4, 32'h22222222, 3, 0, 0, 0, 6);
        check("ack_at_limit_lit", wb_rd_data, 32'h22222222);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
